mul16_nibble_seq: RTL and testbench



---
 rtl/mul_pkg.sv | 18 +
 rtl/bit4_mul.sv | 29 ++
 rtl/mul16_nibble_seq.sv | 104 ++++++++++
 tb/tb_mul16_nibble_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the nibble-serial multiplier: FSM encoding, nibble
// width and the placement shift of one partial-product tile.
package mul_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of the product of x nibble i and y nibble j.
  function automatic int tile_shift(input int i, input int j);
    return NIB * (i + j);
  endfunction

endpackage

// File: rtl/bit4_mul.sv
// Combinational 4x4 unsigned multiplier using one level of Karatsuba on
// 2-bit halves: three 2/3-bit products instead of four.
module bit4_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [1:0] a_hi, a_lo, b_hi, b_lo;
  logic [2:0] sum_a, sum_b;
  logic [3:0] z_hi, z_lo;
  logic [5:0] z_mid_full, z_mid;

  assign a_hi = a[3:2];
  assign a_lo = a[1:0];
  assign b_hi = b[3:2];
  assign b_lo = b[1:0];

  assign z_hi       = {2'b00, a_hi} * {2'b00, b_hi};
  assign z_lo       = {2'b00, a_lo} * {2'b00, b_lo};
  assign sum_a      = {1'b0, a_hi} + {1'b0, a_lo};
  assign sum_b      = {1'b0, b_hi} + {1'b0, b_lo};
  assign z_mid_full = {3'b000, sum_a} * {3'b000, sum_b};
  // Cross term a_hi*b_lo + a_lo*b_hi; never negative, so 6 bits suffice.
  assign z_mid      = z_mid_full - {2'b00, z_hi} - {2'b00, z_lo};

  assign p = {z_hi, 4'b0000} + {z_mid, 2'b00} + {4'b0000, z_lo};

endmodule

// File: rtl/mul16_nibble_seq.sv
// Sequential unsigned multiplier: feeds one nibble pair per cycle to bit4_mul
// and accumulates each shifted 8-bit tile into a 2*OPW-bit product.
module mul16_nibble_seq #(
  parameter int OPW = 16,
  parameter int NIB = mul_pkg::NIB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   X,
  input  logic [OPW-1:0]   Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] Z,
  output logic             busy
);
  import mul_pkg::*;

  localparam int K     = OPW / NIB;
  localparam int TILES = K * K;
  localparam int IDXW  = (TILES > 1) ? $clog2(TILES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TILES - 1);

  if (NIB != 4 || OPW < NIB || (OPW % NIB) != 0) begin : g_bad_param
    $error("mul16_nibble_seq: OPW must be a multiple of 4 and NIB must be 4");
  end

  state_t            state, state_next;
  logic [OPW-1:0]    xr, yr;
  logic [2*OPW-1:0]  acc, acc_sum, tile_ext;
  logic [IDXW-1:0]   idx;
  logic [NIB-1:0]    x_nib, y_nib;
  logic [2*NIB-1:0]  tile;
  logic              last_tile;
  int                nib_i, nib_j;

  assign nib_i     = int'(idx) % K;
  assign nib_j     = int'(idx) / K;
  assign x_nib     = xr[nib_i*NIB +: NIB];
  assign y_nib     = yr[nib_j*NIB +: NIB];
  assign last_tile = (idx == LAST_IDX);

  bit4_mul u_nib_mul (
    .a (x_nib),
    .b (y_nib),
    .p (tile)
  );

  assign tile_ext = {{(2*OPW-2*NIB){1'b0}}, tile};
  assign acc_sum  = acc + (tile_ext << tile_shift(nib_i, nib_j));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: state and datapath registers use <= so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_tile) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr  <= '0;
      yr  <= '0;
      acc <= '0;
      idx <= '0;
      Z   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr  <= X;
            yr  <= Y;
            acc <= '0;
            idx <= '0;
          end
        end
        RUN: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          // Z is loaded only here so it holds steady through DONE and after.
          if (last_tile) Z <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_nibble_seq.sv
// Self-checking bench for mul16_nibble_seq: directed cases from the test plan
// plus a randomized sweep checked against plain X*Y arithmetic.
module tb_mul16_nibble_seq;

  localparam int OPW     = 16;
  localparam int LATENCY = (OPW / 4) * (OPW / 4);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OPW-1:0]   X = '0;
  logic [OPW-1:0]   Y = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*OPW-1:0] Z;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  int          cyc = 0;
  int          n_acc = 0;
  int          n_hs  = 0;
  int          acc_cyc_q[$];
  logic [31:0] hs_z_q[$];

  mul16_nibble_seq #(.OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Handshake monitor: samples at the edge where transfers happen.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      n_acc <= n_acc + 1;
      acc_cyc_q.push_back(cyc);
    end
    if (!rst && out_valid && out_ready) begin
      n_hs <= n_hs + 1;
      hs_z_q.push_back(Z);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; poke drives a stray request during the stall.
  task automatic run_op(input logic [OPW-1:0] x, input logic [OPW-1:0] y,
                        input int stall, input bit poke);
    logic [31:0] exp_z;
    int          lat;
    int          acc_before;
    int          guard;
    exp_z = 32'(x) * 32'(y);
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    X = x;
    Y = y;
    step();
    in_valid = 1'b0;
    X = OPW'($urandom);
    Y = OPW'($urandom);
    check("in_ready_run", in_ready, 0);
    check("busy_run", busy, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("latency", lat, LATENCY);
    check("z_value", Z, exp_z);
    if (stall > 0) begin
      acc_before = n_acc;
      if (poke) begin
        in_valid = 1'b1;
        X = OPW'($urandom);
        Y = OPW'($urandom);
      end
      repeat (stall) step();
      check("stall_out_valid", out_valid, 1);
      check("stall_z", Z, exp_z);
      check("stall_in_ready", in_ready, 0);
      in_valid = 1'b0;
      if (poke) check("stall_no_accept", n_acc, acc_before);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    int hs_before;
    int acc_before;
    int guard;
    int acc_c0;
    int acc_c1;

    repeat (2) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_z", Z, 0);
    rst = 1'b0;
    step();

    run_op(16'h0003, 16'h0005, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op(16'h1234, 16'hABCD, 0, 1'b0);
    check("z_1234_abcd", Z, 32'h0C374FA4);
    run_op(16'h00F0, 16'h0F0F, 10, 1'b1);

    // Abort mid-RUN: no handshake for the aborted operation, no residue.
    hs_before = n_hs;
    in_valid = 1'b1;
    X = 16'h00FF;
    Y = 16'h0101;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_z", Z, 0);
    repeat (20) step();
    check("abort_no_hs", n_hs, hs_before);
    run_op(16'd2, 16'd7, 0, 1'b0);
    check("after_abort_z", Z, 32'd14);

    // Back-to-back with in_valid held high and out_ready held high.
    hs_before  = n_hs;
    acc_before = n_acc;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    X = 16'h8000;
    Y = 16'h0002;
    guard = 0;
    while (n_acc == acc_before && guard < 100) begin
      step();
      guard++;
    end
    X = 16'h0000;
    Y = 16'hFFFF;
    guard = 0;
    while (n_acc == acc_before + 1 && guard < 100) begin
      step();
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (n_hs < hs_before + 2 && guard < 100) begin
      step();
      guard++;
    end
    out_ready = 1'b0;
    step();
    check("b2b_acc_count", n_acc, acc_before + 2);
    check("b2b_hs_count", n_hs, hs_before + 2);
    if (hs_z_q.size() >= 2 && acc_cyc_q.size() >= 2) begin
      check("b2b_z0", hs_z_q[hs_z_q.size()-2], 32'h00010000);
      check("b2b_z1", hs_z_q[hs_z_q.size()-1], 32'h00000000);
      acc_c0 = acc_cyc_q[acc_cyc_q.size()-2];
      acc_c1 = acc_cyc_q[acc_cyc_q.size()-1];
      check("b2b_interval", acc_c1 - acc_c0, LATENCY + 2);
    end else begin
      check("b2b_queue_size", hs_z_q.size(), 2);
    end

    // Random sweep with random stalls and random idle gaps.
    hs_before  = n_hs;
    acc_before = n_acc;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) step();
      run_op(OPW'($urandom), OPW'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    step();
    check("sweep_acc_count", n_acc - acc_before, 1000);
    check("sweep_hs_count", n_hs - hs_before, 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
